// File: rtl/irda_hdlc_bit_stuffer_p.sv
// HDLC/IrDA transmit bit stuffer: serializes words LSB first, inserts a 0 after
// RUN_LEN consecutive 1s, and sends unstuffed 0x7E flags on request.
module irda_hdlc_bit_stuffer_p #(
    parameter int RUN_LEN = 5,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic              bit_en,
    input  logic              restart,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    input  logic              flag_i,
    output logic              tx_bit_o,
    output logic              tx_valid_o,
    output logic              stuffed_o,
    output logic              underrun_o
);

    localparam int OW = $clog2(RUN_LEN + 1);
    localparam int BW = $clog2(DATA_W);
    localparam logic [7:0] FLAG_BYTE = 8'h7E;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_STUFF = 2'd2,
        S_FLAG  = 2'd3
    } state_e;

    state_e            state_q, state_d, sel_s;
    logic [DATA_W-1:0] shift_q, shift_d, src_s;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d, bcnt_s;
    logic [OW-1:0]     ones_cnt_q, ones_cnt_d, ones_s;
    logic [2:0]        flag_cnt_q, flag_cnt_d, fcnt_s;
    logic              hold_full_q, hold_full_d;
    logic              flag_pend_q, flag_pend_d;
    logic              frame_open_q, frame_open_d;
    logic              tx_bit_q, tx_bit_d;
    logic              tx_valid_q, tx_valid_d;
    logic              stuffed_q, stuffed_d;
    logic              underrun_q, underrun_d;
    logic              data_ready_q, data_ready_d;

    // Next-state logic: word acceptance every clk, bit slot processing on bit_en.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        flag_cnt_d   = flag_cnt_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        flag_pend_d  = flag_pend_q;
        frame_open_d = frame_open_q;
        tx_bit_d     = tx_bit_q;
        tx_valid_d   = tx_valid_q;
        stuffed_d    = stuffed_q;
        underrun_d   = 1'b0;
        data_ready_d = data_ready_q;
        sel_s        = state_q;
        src_s        = shift_q;
        bcnt_s       = bit_cnt_q;
        fcnt_s       = flag_cnt_q;
        ones_s       = {OW{1'b0}};
        if (restart) begin
            state_d      = S_IDLE;
            shift_d      = {DATA_W{1'b0}};
            bit_cnt_d    = {BW{1'b0}};
            ones_cnt_d   = {OW{1'b0}};
            flag_cnt_d   = 3'd0;
            hold_d       = {DATA_W{1'b0}};
            hold_full_d  = 1'b0;
            flag_pend_d  = 1'b0;
            frame_open_d = 1'b0;
            tx_bit_d     = 1'b1;
            tx_valid_d   = 1'b0;
            stuffed_d    = 1'b0;
            underrun_d   = 1'b0;
            data_ready_d = 1'b1;
        end else begin
            if (data_valid_i && data_ready_q) begin
                hold_d      = data_i;
                hold_full_d = 1'b1;
            end else begin
                hold_full_d = hold_full_q;
            end
            flag_pend_d = flag_pend_q | flag_i;
            if (bit_en) begin
                // S_IDLE doubles as the word boundary: pick what this slot carries.
                if (state_q == S_IDLE) begin
                    if (flag_pend_q) begin
                        sel_s        = S_FLAG;
                        fcnt_s       = 3'd0;
                        flag_pend_d  = flag_i;
                        frame_open_d = 1'b0;
                    end else if (hold_full_q) begin
                        sel_s        = S_DATA;
                        src_s        = hold_q;
                        bcnt_s       = {BW{1'b0}};
                        hold_full_d  = 1'b0;
                        frame_open_d = 1'b1;
                    end else begin
                        sel_s        = S_IDLE;
                        underrun_d   = frame_open_q;
                        frame_open_d = 1'b0;
                    end
                end else begin
                    sel_s = state_q;
                end
                case (sel_s)
                    S_DATA: begin
                        tx_bit_d   = src_s[0];
                        tx_valid_d = 1'b1;
                        stuffed_d  = 1'b0;
                        shift_d    = {1'b0, src_s[DATA_W-1:1]};
                        ones_s     = src_s[0] ? (ones_cnt_q + OW'(1)) : {OW{1'b0}};
                        ones_cnt_d = ones_s;
                        bit_cnt_d  = (bcnt_s == BW'(DATA_W - 1)) ? {BW{1'b0}} : (bcnt_s + BW'(1));
                        state_d    = (ones_s == OW'(RUN_LEN)) ? S_STUFF :
                                     (bcnt_s == BW'(DATA_W - 1)) ? S_IDLE : S_DATA;
                    end
                    S_STUFF: begin
                        tx_bit_d   = 1'b0;
                        tx_valid_d = 1'b1;
                        stuffed_d  = 1'b1;
                        ones_cnt_d = {OW{1'b0}};
                        state_d    = (bit_cnt_q != {BW{1'b0}}) ? S_DATA : S_IDLE;
                    end
                    S_FLAG: begin
                        tx_bit_d   = FLAG_BYTE[fcnt_s];
                        tx_valid_d = 1'b1;
                        stuffed_d  = 1'b0;
                        ones_cnt_d = {OW{1'b0}};
                        flag_cnt_d = fcnt_s + 3'd1;
                        state_d    = (fcnt_s == 3'd7) ? S_IDLE : S_FLAG;
                    end
                    default: begin
                        tx_bit_d   = 1'b1;
                        tx_valid_d = 1'b0;
                        stuffed_d  = 1'b0;
                        ones_cnt_d = {OW{1'b0}};
                        state_d    = S_IDLE;
                    end
                endcase
            end else begin
                underrun_d = 1'b0;
            end
            data_ready_d = ~hold_full_d;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            shift_q      <= {DATA_W{1'b0}};
            bit_cnt_q    <= {BW{1'b0}};
            ones_cnt_q   <= {OW{1'b0}};
            flag_cnt_q   <= 3'd0;
            hold_q       <= {DATA_W{1'b0}};
            hold_full_q  <= 1'b0;
            flag_pend_q  <= 1'b0;
            frame_open_q <= 1'b0;
            tx_bit_q     <= 1'b1;
            tx_valid_q   <= 1'b0;
            stuffed_q    <= 1'b0;
            underrun_q   <= 1'b0;
            data_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            flag_cnt_q   <= flag_cnt_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            flag_pend_q  <= flag_pend_d;
            frame_open_q <= frame_open_d;
            tx_bit_q     <= tx_bit_d;
            tx_valid_q   <= tx_valid_d;
            stuffed_q    <= stuffed_d;
            underrun_q   <= underrun_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign data_ready_o = data_ready_q;
    assign tx_bit_o     = tx_bit_q;
    assign tx_valid_o   = tx_valid_q;
    assign stuffed_o    = stuffed_q;
    assign underrun_o   = underrun_q;

endmodule

// File: doc/irda_hdlc_bit_stuffer_p.md
IRDA_HDLC_BIT_STUFFER_P -- requirements
Module: irda_hdlc_bit_stuffer_p

Interface
REQ-001 Parameter RUN_LEN, default 5: number of consecutive 1s after which one 0 is inserted (legal range 2..15).
REQ-002 Parameter DATA_W, default 8: width of data words, serialized LSB first (legal range 2..32).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 bit_en  input  1  bit-slot strobe; the bit state advances only on cycles with bit_en=1.
REQ-006 restart  input  1  synchronous clear, effective on any clk cycle regardless of bit_en.
REQ-007 data_i  input  DATA_W  word to transmit.
REQ-008 data_valid_i  input  1  data_i valid.
REQ-009 data_ready_o  output  1  holding register empty; a word transfers when data_valid_i=1 and data_ready_o=1.
REQ-010 flag_i  input  1  one-cycle request to send an unstuffed flag 0x7E.
REQ-011 tx_bit_o  output  1  registered serial bit.
REQ-012 tx_valid_o  output  1  tx_bit_o is a data, stuff or flag bit (0 = idle mark).
REQ-013 stuffed_o  output  1  tx_bit_o is an inserted 0.
REQ-014 underrun_o  output  1  one-cycle pulse: an open frame ran dry.

Function
REQ-015 One-word holding register; data_ready_o = not hold_full (registered); an accepted word sets hold_full.
REQ-016 flag_i sets flag_pending; repeated requests before service merge into one flag.
REQ-017 States: IDLE, DATA, STUFF, FLAG; all transitions occur only on bit_en cycles.
REQ-018 Word-boundary selection (from IDLE, or at the end of DATA/STUFF/FLAG), in priority order: flag_pending -> FLAG (clear flag_pending, clear frame_open); else hold_full -> DATA (load shifter, clear hold_full, set frame_open); else IDLE.
REQ-019 The selected state's first bit is emitted on the same bit_en as the selection; a new word is emitted without a gap.
REQ-020 In IDLE on bit_en: tx_bit_o=1, tx_valid_o=0, stuffed_o=0, ones_cnt=0.
REQ-021 In DATA on bit_en: emit the shifter LSB (tx_valid_o=1); a 1 increments ones_cnt, a 0 clears it; bit counter increments.
REQ-022 If the updated ones_cnt equals RUN_LEN, the next state is STUFF; this holds even on the last bit of a word, so runs carry across word boundaries.
REQ-023 In STUFF on bit_en: tx_bit_o=0, tx_valid_o=1, stuffed_o=1, ones_cnt=0; then return to DATA if bits remain, otherwise apply REQ-018.
REQ-024 In FLAG on bit_en: emit 0,1,1,1,1,1,1,0 over 8 slots with no stuffing; ones_cnt is held at 0.
REQ-025 Underrun: a REQ-018 selection of IDLE while frame_open=1 pulses underrun_o for one clk and clears frame_open.
REQ-026 On bit_en=0 cycles, all bit-side state and tx_* outputs hold; stuffed_o holds; underrun_o=0.
REQ-027 Data acceptance (REQ-015) runs on every clk, independent of bit_en.
REQ-028 The holding register is freed in the same cycle it loads the shifter; data_ready_o rises on the next cycle.
REQ-029 Counter widths: ones_cnt is ceil(log2(RUN_LEN+1)) bits; the bit counter is ceil(log2(DATA_W)) bits; neither wraps.

Reset
REQ-030 wb_rst_i=1 forces: state IDLE, tx_bit_o=1, tx_valid_o=0, stuffed_o=0, underrun_o=0, data_ready_o=1, all counters 0, hold_full=0, flag_pending=0, frame_open=0.
REQ-031 restart=1 applies the same values synchronously, discarding any held word, pending flag and partial word.
REQ-032 restart=1 has priority over a simultaneous data transfer, flag_i and bit_en.
REQ-033 restart=1 generates no underrun_o pulse.

Verification
REQ-034 RUN_LEN=5, word 0xFF, bit_en every cycle -> tx_bit_o 1,1,1,1,1,0,1,1,1, then idle 1s with tx_valid_o=0; stuffed_o=1 only on the 6th slot; underrun_o pulses once.
REQ-035 flag_i, then word 0x7E, then flag_i -> flag 0,1,1,1,1,1,1,0 unstuffed; data 0,1,1,1,1,1,0(stuffed),1,0; flag unstuffed; no underrun_o.
REQ-036 Words 0xF8 then 0x00 -> 0,0,0,1,1,1,1,1,0(stuffed),0x8 zeros; stuff slot occurs between words.
REQ-037 Words 0xE0 then 0x03 -> ones run carries across the boundary; stuffed 0 is emitted after the 2nd bit of 0x03; total 17 valid slots.
REQ-038 bit_en asserted every 4th clk, with restart asserted mid-word -> the next clk shows reset values and the next bit is idle 1; no underrun_o.
REQ-039 RUN_LEN=3, DATA_W=16, word 0xFFFF -> stuffed 0 after every 3rd 1; 21 valid slots.
